// File: rtl/imem_boot_loader_if.sv
// Loader, CPU fetch and memory-port signals of the instruction-memory boot loader.
//   ld_valid/ld_data/ld_last/ld_ready : program-word loader handshake
//   cpu_addr/cpu_instr/cpu_stall      : CPU fetch path and stall indication
//   mem_addr/mem_wdata/mem_we/mem_rdata : single-port instruction memory
// The "slave" modport is the boot loader's view; "master" is the environment's.
interface imem_boot_loader_if #(
    parameter int ADDR_W = 8
);
    logic              ld_valid;
    logic [31:0]       ld_data;
    logic              ld_last;
    logic              ld_ready;
    logic [31:0]       cpu_addr;
    logic [31:0]       cpu_instr;
    logic              cpu_stall;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_we;
    logic [31:0]       mem_rdata;

    modport master (
        output ld_valid, ld_data, ld_last, cpu_addr, mem_rdata,
        input  ld_ready, cpu_instr, cpu_stall, mem_addr, mem_wdata, mem_we
    );

    modport slave (
        input  ld_valid, ld_data, ld_last, cpu_addr, mem_rdata,
        output ld_ready, cpu_instr, cpu_stall, mem_addr, mem_wdata, mem_we
    );
endinterface

// File: rtl/imem_boot_loader.sv
// Instruction-memory boot loader for the single-cycle MIPS core.
// Holds the CPU stalled while a program is streamed in over the loader port,
// zero-fills the rest of the memory, then hands the memory port to the PC.
//
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   reload          : restart loading (honoured only in RUN)
//   bus (slave)     : loader handshake, CPU fetch path, memory port
//   load_done       : high while in RUN
//   words_loaded    : number of loader words accepted
//   load_err        : sticky, memory filled without seeing ld_last
//   misalign        : (only with IMEM_ALIGN_CHECK_EN) sticky misaligned fetch
//
// Build option: define IMEM_ALIGN_CHECK_EN to add misaligned-fetch detection.
//
// state | meaning
// BOOT  | accepting program words, CPU stalled
// CLEAR | zero-filling words after the last loaded one, CPU stalled
// RUN   | memory port follows cpu_addr, CPU running
module imem_boot_loader #(
    parameter int          ADDR_W   = 8,
    parameter int          DEPTH    = 256,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              reload,
    imem_boot_loader_if.slave bus,
    output logic              load_done,
    output logic [ADDR_W:0]   words_loaded,
    output logic              load_err
`ifdef IMEM_ALIGN_CHECK_EN
    ,
    output logic              misalign
`endif
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        CLEAR = 2'd1,
        RUN   = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    state_t            state, state_nx;
    logic [ADDR_W-1:0] wr_ptr, wr_ptr_nx;
    logic [ADDR_W:0]   words_nx;
    logic              err_nx;
`ifdef IMEM_ALIGN_CHECK_EN
    logic              mis_nx;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= BOOT;
            wr_ptr       <= '0;
            words_loaded <= '0;
            load_err     <= 1'b0;
`ifdef IMEM_ALIGN_CHECK_EN
            misalign     <= 1'b0;
`endif
        end else begin
            state        <= state_nx;
            wr_ptr       <= wr_ptr_nx;
            words_loaded <= words_nx;
            load_err     <= err_nx;
`ifdef IMEM_ALIGN_CHECK_EN
            misalign     <= mis_nx;
`endif
        end
    end

    always_comb begin
        state_nx      = state;
        wr_ptr_nx     = wr_ptr;
        words_nx      = words_loaded;
        err_nx        = load_err;
`ifdef IMEM_ALIGN_CHECK_EN
        mis_nx        = misalign;
`endif
        bus.ld_ready  = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_wdata = 32'h0000_0000;
        bus.mem_addr  = wr_ptr;
        bus.cpu_stall = 1'b1;
        bus.cpu_instr = NOP_WORD;
        load_done     = 1'b0;

        unique case (state)
            BOOT: begin
                // ld_ready is constant here, so ld_valid alone marks a transfer.
                bus.ld_ready  = 1'b1;
                bus.mem_wdata = bus.ld_data;
                bus.mem_we    = bus.ld_valid;
                if (bus.ld_valid) begin
                    wr_ptr_nx = wr_ptr + 1'b1;
                    words_nx  = words_loaded + 1'b1;
                    if (wr_ptr == LAST_IDX) begin
                        // Memory is full: nothing left to clear.
                        state_nx = RUN;
                        if (!bus.ld_last) begin
                            err_nx = 1'b1;
                        end
                    end else if (bus.ld_last) begin
                        state_nx = CLEAR;
                    end
                end
            end
            CLEAR: begin
                bus.mem_we = 1'b1;
                wr_ptr_nx  = wr_ptr + 1'b1;
                if (wr_ptr == LAST_IDX) begin
                    state_nx = RUN;
                end
            end
            RUN: begin
                bus.cpu_stall = 1'b0;
                load_done     = 1'b1;
                // Byte address to word index; upper bits drop so fetches wrap.
                bus.mem_addr  = bus.cpu_addr[ADDR_W+1:2];
                bus.cpu_instr = bus.mem_rdata;
`ifdef IMEM_ALIGN_CHECK_EN
                if (bus.cpu_addr[1:0] != 2'b00) begin
                    bus.cpu_instr = NOP_WORD;
                    mis_nx        = 1'b1;
                end
`endif
                if (reload) begin
                    state_nx  = BOOT;
                    wr_ptr_nx = '0;
                    words_nx  = '0;
                    err_nx    = 1'b0;
`ifdef IMEM_ALIGN_CHECK_EN
                    mis_nx    = 1'b0;
`endif
                end
            end
            default: begin
                state_nx = BOOT;
            end
        endcase
    end

endmodule

// File: tb/tb_imem_boot_loader.sv
module tb_imem_boot_loader;

    logic clk = 1'b0;
    logic reset;
    logic reload;
    logic load_done;
    logic [8:0] words_loaded;
    logic load_err;
`ifdef IMEM_ALIGN_CHECK_EN
    logic misalign;
`endif

    int checks = 0;
    int fails  = 0;

    imem_boot_loader_if #(.ADDR_W(8)) bus ();

    imem_boot_loader #(
        .ADDR_W(8),
        .DEPTH(256),
        .NOP_WORD(32'h0000_0000)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .reload       (reload),
        .bus          (bus),
        .load_done    (load_done),
        .words_loaded (words_loaded),
        .load_err     (load_err)
`ifdef IMEM_ALIGN_CHECK_EN
        ,
        .misalign     (misalign)
`endif
    );

    always #5 clk = ~clk;

    // Behavioural instruction memory: synchronous write, combinational read.
    logic [31:0] mem [0:255];
    logic        mem_fill = 1'b0;
    int          wr_count = 0;

    always @(posedge clk) begin
        if (mem_fill) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'hDEAD_BEEF;
        end else if (bus.mem_we) begin
            mem[bus.mem_addr] <= bus.mem_wdata;
            wr_count <= wr_count + 1;
        end
    end

    assign bus.mem_rdata = mem[bus.mem_addr];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; reload = 1'b0;
        bus.ld_valid = 1'b0; bus.ld_data = '0; bus.ld_last = 1'b0; bus.cpu_addr = '0;
        mem_fill = 1'b1;
        tick(); tick();
        mem_fill = 1'b0;
        reset = 1'b0;
        #1;
        checks++; if (bus.ld_ready !== 1'b1) begin fails++; $display("FAIL reset_ld_ready got %b exp 1", bus.ld_ready); end
        checks++; if (bus.mem_we !== 1'b0) begin fails++; $display("FAIL reset_mem_we got %b exp 0", bus.mem_we); end
        checks++; if (bus.cpu_stall !== 1'b1) begin fails++; $display("FAIL reset_cpu_stall got %b exp 1", bus.cpu_stall); end
        checks++; if (load_done !== 1'b0) begin fails++; $display("FAIL reset_load_done got %b exp 0", load_done); end
        checks++; if (bus.cpu_instr !== 32'h0) begin fails++; $display("FAIL reset_cpu_instr got %h exp 00000000", bus.cpu_instr); end
        checks++; if (words_loaded !== 9'd0) begin fails++; $display("FAIL reset_words got %0d exp 0", words_loaded); end
        checks++; if (load_err !== 1'b0) begin fails++; $display("FAIL reset_load_err got %b exp 0", load_err); end
        checks++; if (bus.mem_addr !== 8'd0) begin fails++; $display("FAIL reset_mem_addr got %0d exp 0", bus.mem_addr); end
`ifdef IMEM_ALIGN_CHECK_EN
        checks++; if (misalign !== 1'b0) begin fails++; $display("FAIL reset_misalign got %b exp 0", misalign); end
`endif
    endtask

    task automatic test_load18();
        int base;
        int cnt;
        base = wr_count;
        for (int i = 0; i < 18; i++) begin
            bus.ld_valid = 1'b1;
            bus.ld_data  = 32'h2009_0005 + 32'(i);
            bus.ld_last  = (i == 17);
            #1;
            checks++;
            if (bus.mem_we !== 1'b1 || bus.mem_addr !== 8'(i) || bus.mem_wdata !== 32'h2009_0005 + 32'(i)) begin
                fails++;
                $display("FAIL load18_write[%0d] got we=%b addr=%0d data=%h exp we=1 addr=%0d data=%h",
                         i, bus.mem_we, bus.mem_addr, bus.mem_wdata, i, 32'h2009_0005 + 32'(i));
            end
            tick();
        end
        bus.ld_valid = 1'b0; bus.ld_last = 1'b0;
        #1;
        checks++;
        if (bus.ld_ready !== 1'b0 || bus.mem_we !== 1'b1 || bus.mem_wdata !== 32'h0 || bus.mem_addr !== 8'd18) begin
            fails++;
            $display("FAIL clear_first got ready=%b we=%b data=%h addr=%0d exp ready=0 we=1 data=0 addr=18",
                     bus.ld_ready, bus.mem_we, bus.mem_wdata, bus.mem_addr);
        end
        cnt = 0;
        while (load_done !== 1'b1 && cnt < 300) begin
            checks++;
            if (bus.cpu_stall !== 1'b1) begin fails++; $display("FAIL clear_stall got %b exp 1", bus.cpu_stall); end
            tick();
            cnt++;
        end
        checks++; if (cnt != 238) begin fails++; $display("FAIL clear_cycles got %0d exp 238", cnt); end
        checks++; if (words_loaded !== 9'd18) begin fails++; $display("FAIL load18_words got %0d exp 18", words_loaded); end
        checks++; if (load_err !== 1'b0) begin fails++; $display("FAIL load18_err got %b exp 0", load_err); end
        checks++; if (wr_count - base != 256) begin fails++; $display("FAIL load18_total_writes got %0d exp 256", wr_count - base); end
        checks++; if (bus.mem_we !== 1'b0) begin fails++; $display("FAIL run_mem_we got %b exp 0", bus.mem_we); end
    endtask

    task automatic test_fetch();
        bus.cpu_addr = 32'h8; #1;
        checks++; if (bus.cpu_instr !== 32'h2009_0007) begin fails++; $display("FAIL fetch_0x8 got %h exp 20090007", bus.cpu_instr); end
        checks++; if (bus.cpu_stall !== 1'b0) begin fails++; $display("FAIL fetch_stall got %b exp 0", bus.cpu_stall); end
        bus.cpu_addr = 32'h44; #1;
        checks++; if (bus.cpu_instr !== 32'h2009_0016) begin fails++; $display("FAIL fetch_0x44 got %h exp 20090016", bus.cpu_instr); end
        bus.cpu_addr = 32'h48; #1;
        checks++; if (bus.cpu_instr !== 32'h0) begin fails++; $display("FAIL fetch_0x48 got %h exp 00000000", bus.cpu_instr); end
        bus.cpu_addr = 32'h408; #1;
        checks++; if (bus.cpu_instr !== 32'h2009_0007 || bus.mem_addr !== 8'd2) begin
            fails++; $display("FAIL fetch_wrap got instr=%h addr=%0d exp 20090007 addr=2", bus.cpu_instr, bus.mem_addr);
        end
`ifndef IMEM_ALIGN_CHECK_EN
        bus.cpu_addr = 32'h6; #1;
        checks++; if (bus.cpu_instr !== 32'h2009_0006) begin fails++; $display("FAIL fetch_unaligned got %h exp 20090006", bus.cpu_instr); end
`endif
        bus.ld_valid = 1'b1; bus.ld_data = 32'hFFFF_FFFF; #1;
        checks++; if (bus.mem_we !== 1'b0) begin fails++; $display("FAIL run_ld_ignored got we=%b exp 0", bus.mem_we); end
        tick();
        bus.ld_valid = 1'b0; bus.cpu_addr = 32'h8; #1;
        checks++; if (bus.cpu_instr !== 32'h2009_0007 || words_loaded !== 9'd18) begin
            fails++; $display("FAIL run_after_ld got instr=%h words=%0d exp 20090007 18", bus.cpu_instr, words_loaded);
        end
        bus.cpu_addr = 32'h0;
    endtask

    task automatic test_reload_boot();
        reload = 1'b1; tick(); reload = 1'b0; #1;
        checks++; if (bus.ld_ready !== 1'b1 || load_done !== 1'b0 || bus.cpu_stall !== 1'b1) begin
            fails++; $display("FAIL reload_boot got ready=%b done=%b stall=%b exp 1 0 1", bus.ld_ready, load_done, bus.cpu_stall);
        end
        checks++; if (words_loaded !== 9'd0) begin fails++; $display("FAIL reload_words got %0d exp 0", words_loaded); end
        reload = 1'b1; tick(); reload = 1'b0; #1;
        checks++; if (bus.ld_ready !== 1'b1 || bus.mem_addr !== 8'd0) begin
            fails++; $display("FAIL reload_in_boot got ready=%b addr=%0d exp 1 0", bus.ld_ready, bus.mem_addr);
        end
    endtask

    task automatic test_toggle_valid();
        int base;
        int idx;
        base = wr_count;
        idx = 0;
        for (int c = 0; c < 8; c++) begin
            bus.ld_valid = (c % 2 == 0);
            bus.ld_data  = 32'hA000_0000 + 32'(c);
            bus.ld_last  = 1'b0;
            #1;
            checks++;
            if (bus.mem_we !== bus.ld_valid || bus.cpu_stall !== 1'b1 || (bus.ld_valid && bus.mem_addr !== 8'(idx))) begin
                fails++;
                $display("FAIL toggle[%0d] got we=%b addr=%0d stall=%b exp we=%b addr=%0d stall=1",
                         c, bus.mem_we, bus.mem_addr, bus.cpu_stall, bus.ld_valid, idx);
            end
            if (bus.ld_valid) idx++;
            tick();
        end
        bus.ld_valid = 1'b0; #1;
        checks++; if (wr_count - base != 4) begin fails++; $display("FAIL toggle_writes got %0d exp 4", wr_count - base); end
        checks++; if (words_loaded !== 9'd4) begin fails++; $display("FAIL toggle_words got %0d exp 4", words_loaded); end
        checks++; if (mem[3] !== 32'hA000_0006) begin fails++; $display("FAIL toggle_mem3 got %h exp A0000006", mem[3]); end
    endtask

    task automatic test_full256();
        reset = 1'b1; tick(); reset = 1'b0;
        for (int i = 0; i < 256; i++) begin
            bus.ld_valid = 1'b1;
            bus.ld_data  = 32'(i * 3 + 1);
            bus.ld_last  = 1'b0;
            #1;
            checks++;
            if (bus.mem_we !== 1'b1 || bus.mem_addr !== 8'(i)) begin
                fails++; $display("FAIL full_write[%0d] got we=%b addr=%0d exp we=1 addr=%0d", i, bus.mem_we, bus.mem_addr, i);
            end
            tick();
        end
        bus.ld_valid = 1'b0; #1;
        checks++; if (load_done !== 1'b1) begin fails++; $display("FAIL full_run_now got %b exp 1", load_done); end
        checks++; if (load_err !== 1'b1) begin fails++; $display("FAIL full_err got %b exp 1", load_err); end
        checks++; if (words_loaded !== 9'd256) begin fails++; $display("FAIL full_words got %0d exp 256", words_loaded); end
        bus.cpu_addr = 32'h3FC; #1;
        checks++; if (bus.cpu_instr !== 32'd766) begin fails++; $display("FAIL full_fetch255 got %h exp %h", bus.cpu_instr, 32'd766); end
        bus.cpu_addr = 32'h0;
    endtask

    task automatic test_reload_clears_err();
        reload = 1'b1; tick(); reload = 1'b0; #1;
        checks++; if (load_err !== 1'b0 || words_loaded !== 9'd0 || bus.ld_ready !== 1'b1) begin
            fails++; $display("FAIL reload_err got err=%b words=%0d ready=%b exp 0 0 1", load_err, words_loaded, bus.ld_ready);
        end
    endtask

    task automatic test_reset_mid_clear();
        bus.ld_valid = 1'b1; bus.ld_data = 32'h1234_5678; bus.ld_last = 1'b1;
        tick();
        bus.ld_valid = 1'b0; bus.ld_last = 1'b0;
        for (int i = 0; i < 99; i++) tick();
        checks++; if (bus.mem_addr !== 8'd100 || bus.mem_we !== 1'b1) begin
            fails++; $display("FAIL mid_clear_ptr got addr=%0d we=%b exp 100 1", bus.mem_addr, bus.mem_we);
        end
        reset = 1'b1; reload = 1'b1; tick(); reset = 1'b0; reload = 1'b0; #1;
        checks++; if (bus.ld_ready !== 1'b1 || bus.mem_we !== 1'b0 || words_loaded !== 9'd0 || load_done !== 1'b0) begin
            fails++; $display("FAIL mid_clear_reset got ready=%b we=%b words=%0d done=%b exp 1 0 0 0",
                              bus.ld_ready, bus.mem_we, words_loaded, load_done);
        end
    endtask

`ifdef IMEM_ALIGN_CHECK_EN
    task automatic test_misalign();
        int cnt;
        reset = 1'b1; tick(); reset = 1'b0;
        bus.ld_valid = 1'b1; bus.ld_data = 32'h1111_1111; bus.ld_last = 1'b1;
        tick();
        bus.ld_valid = 1'b0; bus.ld_last = 1'b0;
        cnt = 0;
        while (load_done !== 1'b1 && cnt < 300) begin tick(); cnt++; end
        checks++; if (cnt != 255) begin fails++; $display("FAIL mis_clear_cycles got %0d exp 255", cnt); end
        bus.cpu_addr = 32'h6; #1;
        checks++; if (bus.cpu_instr !== 32'h0 || misalign !== 1'b0) begin
            fails++; $display("FAIL mis_comb got instr=%h mis=%b exp 00000000 0", bus.cpu_instr, misalign);
        end
        tick();
        checks++; if (misalign !== 1'b1) begin fails++; $display("FAIL mis_set got %b exp 1", misalign); end
        bus.cpu_addr = 32'h0; tick();
        checks++; if (misalign !== 1'b1 || bus.cpu_instr !== 32'h1111_1111) begin
            fails++; $display("FAIL mis_sticky got mis=%b instr=%h exp 1 11111111", misalign, bus.cpu_instr);
        end
        reload = 1'b1; tick(); reload = 1'b0; #1;
        checks++; if (misalign !== 1'b0) begin fails++; $display("FAIL mis_reload got %b exp 0", misalign); end
    endtask
`endif

    initial begin
        test_reset();
        test_load18();
        test_fetch();
        test_reload_boot();
        test_toggle_valid();
        test_full256();
        test_reload_clears_err();
        test_reset_mid_clear();
`ifdef IMEM_ALIGN_CHECK_EN
        test_misalign();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/imem_boot_loader.md
Name: imem_boot_loader

Overview:
- Sequences the single-cycle MIPS instruction memory through its two phases: program load, then fetch.
- At reset it holds the CPU stalled and accepts the program word-by-word over a valid/ready loader port.
- Once loading ends, it zero-fills every remaining word and switches the memory port to the PC fetch path.
- Replaces file-based preload with a loadable, restartable boot sequence.

Parameters:
- ADDR_W, 8, word-index width of the memory port.
- DEPTH, 256, number of 32-bit words; must equal 2**ADDR_W.
- NOP_WORD, 32'h00000000, instruction returned to the CPU while stalled.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- ld_valid  in  1  loader word valid.
- ld_data  in  32  loader instruction word.
- ld_last  in  1  qualifies the final program word.
- ld_ready  out  1  loader may transfer.
- reload  in  1  restart loading from RUN.
- cpu_addr  in  32  byte address from PC.
- cpu_instr  out  32  instruction to the decoder.
- cpu_stall  out  1  CPU must hold PC and suppress writes.
- mem_addr  out  ADDR_W  word index to memory.
- mem_wdata  out  32  write data to memory.
- mem_we  out  1  synchronous write enable to memory.
- mem_rdata  in  32  combinational read data from memory.
- load_done  out  1  high in RUN.
- words_loaded  out  ADDR_W+1  count of loader words accepted.
- load_err  out  1  sticky: memory filled without ld_last.

Behaviour:
- States are BOOT, CLEAR and RUN; state is registered, outputs decode combinationally from state except where noted.
- Registers: wr_ptr (ADDR_W), words_loaded, load_err.
- Reset (checked every edge, wins over all else): state=BOOT, wr_ptr=0, words_loaded=0, load_err=0. Memory contents are not touched by reset.
- Outputs after reset: ld_ready=1, mem_we=0, cpu_stall=1, load_done=0, cpu_instr=NOP_WORD.

BOOT:
- ld_ready=1.
- mem_addr=wr_ptr, mem_wdata=ld_data, mem_we=ld_valid.
- A transfer occurs on an edge with ld_valid&&ld_ready; on each transfer, wr_ptr++ and words_loaded++.
- Transfer with ld_last at wr_ptr<DEPTH-1: go to CLEAR with wr_ptr+1.
- Transfer at wr_ptr==DEPTH-1: go to RUN. If ld_last==0 on that transfer, set load_err=1. wr_ptr wraps to 0.
- With no ld_valid, the block holds state indefinitely.

CLEAR:
- ld_ready=0, mem_we=1, mem_wdata=0, mem_addr=wr_ptr.
- wr_ptr++ each cycle.
- The edge that writes index DEPTH-1 moves state to RUN.
- Duration is DEPTH-1-k cycles, where k is the index of the last loaded word.

RUN:
- ld_ready=0, mem_we=0, cpu_stall=0, load_done=1.
- mem_addr=cpu_addr[ADDR_W+1:2]; cpu_instr=mem_rdata with zero added latency.
- cpu_addr bits above ADDR_W+1 are ignored, so addresses wrap modulo DEPTH words.
- reload=1: next state BOOT, wr_ptr=0, words_loaded=0, load_err=0.

Stalled states and precedence:
- In BOOT and CLEAR: cpu_stall=1, cpu_instr=NOP_WORD.
- reload is ignored in BOOT and CLEAR.
- reset together with reload: reset wins; the result is identical.
- ld_valid outside BOOT is ignored; no write occurs.

Optional Feature:
- Macro: IMEM_ALIGN_CHECK_EN.
- Defined: adds output misalign (1 bit, reset 0). In RUN, when cpu_addr[1:0]!=0:
  - cpu_instr=NOP_WORD;
  - misalign goes high registered on that edge and stays sticky until reset or reload.
- Not defined: no misalign port; cpu_addr[1:0] is ignored and fetch proceeds from the truncated word index.

Test Plan:
- Reset, then 18 words 0x20090005.. with ld_last on word 17 -> 18 writes at mem_addr 0..17; CLEAR for 238 cycles; load_done rises exactly 238 edges after the last-word edge; words_loaded=18; load_err=0.
- After that load, cpu_addr=0x8 -> cpu_instr=word 2 in the same cycle; cpu_addr=0x48 -> 0x00000000 (zero-filled); cpu_addr=0x408 -> word 2 (wrap).
- ld_valid toggled 1/0 every cycle for 4 words -> exactly 4 writes at consecutive indices 0..3; no write on idle cycles; cpu_stall=1 throughout.
- 256 words without ld_last -> RUN immediately after word 255, no CLEAR cycles, load_err=1, words_loaded=256.
- reset asserted mid-CLEAR at wr_ptr=100 -> next cycle BOOT, ld_ready=1, mem_we=0, words_loaded=0; reload in RUN -> BOOT with load_err cleared.
- With IMEM_ALIGN_CHECK_EN, in RUN set cpu_addr=0x6 -> cpu_instr=0x00000000, misalign=1 after the edge and held until reload.
